traffic_datapath: RTL
=====================

// Module: traffic_datapath
// PURPOSE
//  Timer/display datapath paired with the traffic-light control FSM: consumes load, twentyToLoad,
//  displaySignal, hwy, cntry; returns counterNotZero and counterNotFive. Holds a 1 Hz prescaler
//  and a seconds down-counter. Drives four active-low 7-seg digits and one-hot lamp outputs.
//  Sits beside the FSM at top level on the CLOCK_50 domain.
// PARAMETERS
//  TICK_DIV    50_000_000  CLOCK_50 cycles per one-second tick (sim: 4)
//  CNT_W       5           down-counter width; max count 2**CNT_W-1
//  SHORT_COUNT 5           value loaded when load=1, twentyToLoad=0
//  LONG_COUNT  20          value loaded when load=1, twentyToLoad=1
//  MARK_COUNT  5           value that deasserts counterNotFive
// PORTS
//  CLOCK_50        in   1      system clock
//  reset           in   1      asynchronous, active-low reset
//  load            in   1      FSM: reload counter this cycle
//  twentyToLoad    in   1      FSM: select LONG_COUNT (1) / SHORT_COUNT (0)
//  displaySignal   in   2      FSM: 00 Crgo, 01 Hrgo, 10 Timer, 11 Stop
//  hwy, cntry      in   2 each FSM lamp codes: 00 G, 01 Y, 10 R, 11 invalid
//  counterNotZero  out  1      count != 0
//  counterNotFive  out  1      count != MARK_COUNT
//  count           out  CNT_W  current seconds value (debug/LED)
//  HEX3..HEX0      out  7 each active-low segments {g,f,e,d,c,b,a}
//  hwyLamp         out  3      one-hot {R,Y,G}
//  cntryLamp       out  3      one-hot {R,Y,G}
// BEHAVIOUR
//  Reset (async, reset=0): prescaler=0, count=0, tick=0 -> counterNotZero=0, counterNotFive=1;
//   HEX* and lamps follow inputs combinationally (no registered display state).
//  Prescaler: counts 0..TICK_DIV-1 while load=0; tick=1 for exactly one cycle at TICK_DIV-1,
//   then wraps to 0. load=1 clears prescaler to 0 -> first decrement exactly TICK_DIV cycles
//   after the last cycle with load=1.
//  Counter, priority per rising edge: (1) load=1 -> count<=twentyToLoad?LONG_COUNT:SHORT_COUNT;
//   (2) else tick && count!=0 -> count<=count-1; (3) else hold. Saturates at 0, never wraps.
//  load held several cycles: reload each cycle; countdown starts after release.
//  load and tick in same cycle: load wins, tick discarded.
//  counterNotZero/counterNotFive: combinational from count register; valid the cycle after load.
//  Display (combinational from displaySignal, count):
//   Crgo -> "CrGO"; Hrgo -> "HrGO"; Stop -> "StOP" (HEX3..HEX0, letters left to right)
//   Timer -> HEX3,HEX2 blank (7'h7F); HEX1=tens, HEX0=units of count; tens shown as digit,
//    including 0 (e.g. "05")
//  Lamps: G->3'b001, Y->3'b010, R->3'b100; code 11 -> 3'b000 (dark, fault-visible).
//  Outputs settle in the same cycle the FSM changes; no added latency beyond the count register.
// STRUCTURE
//  Shared include traffic_defs.vh: displaySignal codes (Crgo/Hrgo/Timer/Stop),
//   lamp codes (G/Y/R), 7-seg glyph constants (0-9, C, r, G, O, H, S, t, P, blank).
//  The same include is consumed by the FSM; no local redefinition.
//  Sub-module seven_seg_decoder: 4-bit digit/glyph index -> 7-bit active-low segments;
//   instantiated four times. Prescaler, counter, BCD split and lamp decode stay in this module.
// TESTING  (TICK_DIV=4)
//  1) reset=0 mid-count (count=13) -> count=0, counterNotZero=0, counterNotFive=1 immediately
//  2) load=1,twentyToLoad=0 for 1 cycle -> count=5, counterNotFive=0; 4 cycles later count=4,
//     counterNotFive=1; reaches 0 after 20 cycles; held at 0 for 10 more cycles
//  3) load=1,twentyToLoad=1 then release -> counterNotFive falls exactly 60 cycles later
//     (count 20->5); counterNotZero falls 20 cycles after that
//  4) load asserted on the cycle tick would fire -> count reloads, no decrement; next decrement
//     exactly 4 cycles after load drops
//  5) displaySignal=10, count=17 -> HEX1=glyph 1, HEX0=glyph 7, HEX3/HEX2=7'h7F;
//     displaySignal=11 -> "StOP"
//  6) hwy=00,cntry=10 -> hwyLamp=001, cntryLamp=100; hwy=11 -> hwyLamp=000

Source files
------------

// File: rtl/traffic_datapath_pkg.sv
// Shared definitions for the traffic-light datapath and its FSM: display and lamp codes,
// glyph indices and active-low {g,f,e,d,c,b,a} segment patterns.
package traffic_datapath_pkg;

  typedef enum logic [1:0] {
    DISP_CRGO  = 2'b00,
    DISP_HRGO  = 2'b01,
    DISP_TIMER = 2'b10,
    DISP_STOP  = 2'b11
  } disp_e;

  typedef enum logic [1:0] {
    LAMP_G   = 2'b00,
    LAMP_Y   = 2'b01,
    LAMP_R   = 2'b10,
    LAMP_BAD = 2'b11
  } lamp_e;

  // Letters O and S share the digit glyphs 0 and 5, which keeps the index at 4 bits.
  localparam logic [3:0] GLY_O = 4'd0;
  localparam logic [3:0] GLY_S = 4'd5;
  localparam logic [3:0] GLY_C = 4'd10;
  localparam logic [3:0] GLY_R = 4'd11;
  localparam logic [3:0] GLY_G = 4'd12;
  localparam logic [3:0] GLY_H = 4'd13;
  localparam logic [3:0] GLY_T = 4'd14;
  localparam logic [3:0] GLY_P = 4'd15;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_G     = 7'h42;
  localparam logic [6:0] SEG_H     = 7'h09;
  localparam logic [6:0] SEG_T     = 7'h07;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Invalid lamp code goes dark so a controller fault is visible on the board.
  function automatic logic [2:0] lamp_decode(input logic [1:0] code);
    logic [2:0] lamp;
    lamp = 3'b000;
    case (code)
      LAMP_G:  lamp = 3'b001;
      LAMP_Y:  lamp = 3'b010;
      LAMP_R:  lamp = 3'b100;
      default: lamp = 3'b000;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/traffic_datapath_seven_seg_decoder.sv
// Glyph index to active-low 7-segment pattern; blank_i overrides the index.
module seven_seg_decoder
  import traffic_datapath_pkg::*;
(
  input  logic [3:0] glyph_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (glyph_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        GLY_C:   seg_o = SEG_C;
        GLY_R:   seg_o = SEG_R;
        GLY_G:   seg_o = SEG_G;
        GLY_H:   seg_o = SEG_H;
        GLY_T:   seg_o = SEG_T;
        GLY_P:   seg_o = SEG_P;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/traffic_datapath.sv
// Traffic-light timer/display datapath: 1 Hz prescaler, saturating seconds down-counter,
// four-digit status/timer display and one-hot lamp decode.
module traffic_datapath
  import traffic_datapath_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int CNT_W       = 5,
  parameter int SHORT_COUNT = 5,
  parameter int LONG_COUNT  = 20,
  parameter int MARK_COUNT  = 5
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             load,
  input  logic             twentyToLoad,
  input  logic [1:0]       displaySignal,
  input  logic [1:0]       hwy,
  input  logic [1:0]       cntry,
  output logic             counterNotZero,
  output logic             counterNotFive,
  output logic [CNT_W-1:0] count,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX0,
  output logic [2:0]       hwyLamp,
  output logic [2:0]       cntryLamp
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick;

  assign tick = (presc_q == PRESC_LAST);

  // Load restarts the second so the first decrement lands a full period after release.
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (load || tick) presc_d = '0;
  end

  always_comb begin
    count_d = count_q;
    if (load)                         count_d = twentyToLoad ? CNT_W'(LONG_COUNT) : CNT_W'(SHORT_COUNT);
    else if (tick && count_q != '0)   count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  assign count          = count_q;
  assign counterNotZero = (count_q != '0);
  assign counterNotFive = (count_q != CNT_W'(MARK_COUNT));

  logic [3:0] tens, units;
  assign tens  = 4'(int'(count_q) / 10);
  assign units = 4'(int'(count_q) % 10);

  logic [3:0] gly3, gly2, gly1, gly0;
  logic       blank_hi;

  always_comb begin
    gly3     = GLY_C;
    gly2     = GLY_R;
    gly1     = GLY_G;
    gly0     = GLY_O;
    blank_hi = 1'b0;
    case (displaySignal)
      DISP_CRGO: begin
        gly3 = GLY_C; gly2 = GLY_R; gly1 = GLY_G; gly0 = GLY_O;
      end
      DISP_HRGO: begin
        gly3 = GLY_H; gly2 = GLY_R; gly1 = GLY_G; gly0 = GLY_O;
      end
      DISP_TIMER: begin
        blank_hi = 1'b1;
        gly1     = tens;
        gly0     = units;
      end
      DISP_STOP: begin
        gly3 = GLY_S; gly2 = GLY_T; gly1 = GLY_O; gly0 = GLY_P;
      end
      default: blank_hi = 1'b1;
    endcase
  end

  seven_seg_decoder u_hex3 (.glyph_i(gly3), .blank_i(blank_hi), .seg_o(HEX3));
  seven_seg_decoder u_hex2 (.glyph_i(gly2), .blank_i(blank_hi), .seg_o(HEX2));
  seven_seg_decoder u_hex1 (.glyph_i(gly1), .blank_i(1'b0),     .seg_o(HEX1));
  seven_seg_decoder u_hex0 (.glyph_i(gly0), .blank_i(1'b0),     .seg_o(HEX0));

  assign hwyLamp   = lamp_decode(hwy);
  assign cntryLamp = lamp_decode(cntry);

endmodule
